sonar_scheduler: RTL and testbench

SONAR_SCHEDULER -- requirements
Module: sonar_scheduler

---
 rtl/sonar_scheduler.sv | 200 ++++++++++++++++++++
 tb/tb_sonar_scheduler.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sonar_scheduler.sv
// Round-robin scheduler for up to six ultrasonic rangers: fires one trigger at a
// time, times the echo pulse in microseconds and hands back one result word per
// channel over a valid/ready port, with a crosstalk guard gap between channels.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | no channel enabled; waiting for a nonzero mask
// S_TRIG     | trig[idx] held high for TRIG_US microseconds
// S_WAIT_RISE| waiting for echo[idx] to rise, timeout running
// S_MEASURE  | counting echo width in us, timeout still running
// S_REPORT   | result presented, stalled until res_ready
// S_GAP      | guard interval before the next enabled channel
module sonar_scheduler #(
    parameter int CLK_MHZ    = 50,
    parameter int TRIG_US    = 10,
    parameter int TIMEOUT_US = 30000,
    parameter int GAP_US     = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_valid,
    input  logic [5:0]  cfg_mask,
    input  logic [5:0]  echo,
    output logic [5:0]  trig,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [27:0] res_data,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_TRIG, S_WAIT_RISE, S_MEASURE, S_REPORT, S_GAP
    } state_t;

    localparam int              PW         = (CLK_MHZ > 1) ? $clog2(CLK_MHZ) : 1;
    localparam logic [PW-1:0]   PRESC_LAST = PW'(CLK_MHZ - 1);
    localparam logic [15:0]     TRIG_LAST  = 16'(TRIG_US - 1);
    localparam logic [15:0]     TMO_LAST   = 16'(TIMEOUT_US - 1);
    localparam logic [15:0]     GAP_LAST   = 16'(GAP_US - 1);

    state_t        state_q, state_d;
    logic [5:0]    mask_q, mask_d;
    logic [2:0]    idx_q, idx_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [15:0]   us_cnt_q, us_cnt_d;
    logic [15:0]   width_q, width_d;
    logic [27:0]   res_data_q, res_data_d;
    logic [5:0]    echo_s1_q, echo_s1_d;
    logic [5:0]    echo_s2_q, echo_s2_d;
    logic [5:0]    echo_prev_q, echo_prev_d;

    logic tick;
    logic echo_cur;
    logic echo_old;
    logic tmo_hit;

    function automatic logic [2:0] lowest_idx(input logic [5:0] m);
        lowest_idx = 3'd0;
        for (int i = 5; i >= 0; i--) begin
            if (m[i]) lowest_idx = 3'(i);
        end
    endfunction

    // Next enabled channel strictly above cur, wrapping to the lowest one.
    function automatic logic [2:0] next_idx(input logic [5:0] m, input logic [2:0] cur);
        next_idx = lowest_idx(m);
        for (int i = 5; i >= 0; i--) begin
            if (m[i] && (3'(i) > cur)) next_idx = 3'(i);
        end
    endfunction

    assign tick     = (presc_q == PRESC_LAST);
    assign echo_cur = echo_s2_q[idx_q];
    assign echo_old = echo_prev_q[idx_q];
    assign tmo_hit  = tick && (us_cnt_q == TMO_LAST);

    // Next-state, counter and result computation.
    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        idx_d       = idx_q;
        presc_d     = tick ? '0 : presc_q + 1'b1;
        us_cnt_d    = us_cnt_q;
        width_d     = width_q;
        res_data_d  = res_data_q;
        echo_s1_d   = echo;
        echo_s2_d   = echo_s1_q;
        echo_prev_d = echo_s2_q;

        if (cfg_valid) mask_d = cfg_mask;

        case (state_q)
            S_IDLE: begin
                if (mask_q != 6'd0) begin
                    idx_d    = lowest_idx(mask_q);
                    us_cnt_d = '0;
                    state_d  = S_TRIG;
                end
            end
            S_TRIG: begin
                if (tick) begin
                    if (us_cnt_q == TRIG_LAST) begin
                        us_cnt_d = '0;
                        state_d  = S_WAIT_RISE;
                    end else begin
                        us_cnt_d = us_cnt_q + 16'd1;
                    end
                end
            end
            S_WAIT_RISE: begin
                if (tick) us_cnt_d = us_cnt_q + 16'd1;
                // Timeout wins a same-cycle race so the counter can never run past it.
                if (tmo_hit) begin
                    res_data_d = {1'b0, idx_q, 7'd0, 1'b1, 16'd0};
                    state_d    = S_REPORT;
                end else if (echo_cur && !echo_old) begin
                    width_d = '0;
                    state_d = S_MEASURE;
                end
            end
            S_MEASURE: begin
                if (tick) us_cnt_d = us_cnt_q + 16'd1;
                if (tick && echo_cur && (width_q != 16'hFFFF)) width_d = width_q + 16'd1;
                if (tmo_hit) begin
                    res_data_d = {1'b0, idx_q, 7'd0, 1'b1, width_q};
                    state_d    = S_REPORT;
                end else if (!echo_cur && echo_old) begin
                    res_data_d = {1'b0, idx_q, 7'd0, 1'b0, width_q};
                    state_d    = S_REPORT;
                end
            end
            S_REPORT: begin
                if (res_ready) begin
                    us_cnt_d = '0;
                    state_d  = S_GAP;
                end
            end
            S_GAP: begin
                if (tick) begin
                    if (us_cnt_q == GAP_LAST) begin
                        us_cnt_d = '0;
                        if (mask_q != 6'd0) begin
                            idx_d   = next_idx(mask_q, idx_q);
                            state_d = S_TRIG;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        us_cnt_d = us_cnt_q + 16'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A zero mask aborts whatever is in flight; any pending result is dropped.
        if (cfg_valid && (cfg_mask == 6'd0)) begin
            state_d  = S_IDLE;
            us_cnt_d = '0;
        end

        // Trigger and width timing start on a clean microsecond boundary.
        if (((state_d == S_TRIG) && (state_q != S_TRIG)) ||
            ((state_d == S_MEASURE) && (state_q != S_MEASURE)))
            presc_d = '0;
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            mask_q      <= '0;
            idx_q       <= '0;
            presc_q     <= '0;
            us_cnt_q    <= '0;
            width_q     <= '0;
            res_data_q  <= '0;
            echo_s1_q   <= '0;
            echo_s2_q   <= '0;
            echo_prev_q <= '0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            idx_q       <= idx_d;
            presc_q     <= presc_d;
            us_cnt_q    <= us_cnt_d;
            width_q     <= width_d;
            res_data_q  <= res_data_d;
            echo_s1_q   <= echo_s1_d;
            echo_s2_q   <= echo_s2_d;
            echo_prev_q <= echo_prev_d;
        end
    end

    assign trig      = (state_q == S_TRIG) ? (6'd1 << idx_q) : 6'd0;
    assign res_valid = (state_q == S_REPORT);
    assign res_data  = res_data_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_sonar_scheduler.sv
// Directed bench for sonar_scheduler: 50 clocks/us, 10 us trigger, 200 us
// timeout and a shortened 20 us guard gap so a full scan fits a short run.
module tb_sonar_scheduler;

    logic        clk;
    logic        rst;
    logic        cfg_valid;
    logic [5:0]  cfg_mask;
    logic [5:0]  echo;
    logic [5:0]  trig;
    logic        res_valid;
    logic        res_ready;
    logic [27:0] res_data;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;
    int trig_hi [6];
    int onehot_bad = 0;

    sonar_scheduler #(
        .CLK_MHZ(50), .TRIG_US(10), .TIMEOUT_US(200), .GAP_US(20)
    ) dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_mask(cfg_mask),
        .echo(echo), .trig(trig), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial for (int b = 0; b < 6; b++) trig_hi[b] = 0;

    always @(negedge clk) begin
        for (int b = 0; b < 6; b++) if (trig[b] === 1'b1) trig_hi[b]++;
        if ($countones(trig) > 1) onehot_bad++;
    end

    task automatic do_reset();
        rst = 1'b1; cfg_valid = 1'b0; cfg_mask = '0; echo = '0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic send_cfg(input logic [5:0] m);
        cfg_mask = m; cfg_valid = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    // Waits for a trigger pulse, returns its pattern, length and start latency.
    task automatic wait_trig(input int budget, output logic [5:0] t, output int w,
                             output int lat, output bit to);
        to = 1'b1; t = '0; w = 0; lat = 0;
        for (int n = 1; n <= budget; n++) begin
            @(negedge clk);
            if (trig !== 6'd0) begin to = 1'b0; lat = n; break; end
        end
        if (!to) begin
            t = trig;
            while (trig !== 6'd0 && w < 5000) begin
                w++;
                @(negedge clk);
            end
        end
    endtask

    task automatic wait_res(input int budget, output logic [27:0] d, output int lat,
                            output bit to);
        to = 1'b1; d = '0; lat = 0;
        for (int n = 1; n <= budget; n++) begin
            @(negedge clk);
            if (res_valid === 1'b1) begin to = 1'b0; lat = n; d = res_data; break; end
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (trig !== 6'h00) $display("FAIL reset_trig got=%h exp=00", trig); else n_pass++;
        n_checks++; if (res_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", res_valid); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else n_pass++;
        n_checks++; if (res_data !== 28'h0) $display("FAIL reset_data got=%h exp=0", res_data); else n_pass++;
    endtask

    task automatic test_full_scan();
        logic [5:0]  t, exp_t;
        logic [27:0] d, exp_d;
        int w, lat, rl;
        bit to;
        do_reset();
        res_ready = 1'b1;
        send_cfg(6'h3F);
        for (int i = 0; i < 6; i++) begin
            exp_t = 6'd1 << i;
            wait_trig(20000, t, w, lat, to);
            n_checks++;
            if (to || t !== exp_t) $display("FAIL scan_trig%0d got=%h exp=%h timeout=%0d", i, t, exp_t, to);
            else n_pass++;
            if (i == 0) begin
                n_checks++;
                if (lat !== 1) $display("FAIL scan_latency got=%0d exp=1", lat); else n_pass++;
            end
            n_checks++;
            if (w !== 500) $display("FAIL scan_width%0d got=%0d exp=500", i, w); else n_pass++;
            repeat (5000) @(negedge clk);
            echo[i] = 1'b1;
            repeat (475) @(negedge clk);
            echo[i] = 1'b0;
            exp_d = {4'(i), 7'd0, 1'b0, 16'd9};
            wait_res(2000, d, rl, to);
            n_checks++;
            if (to || d !== exp_d) $display("FAIL scan_res%0d got=%h exp=%h timeout=%0d", i, d, exp_d, to);
            else n_pass++;
        end
        wait_trig(20000, t, w, lat, to);
        n_checks++;
        if (to || t !== 6'h01) $display("FAIL scan_second_pass got=%h exp=01", t); else n_pass++;
        send_cfg(6'h00);
    endtask

    task automatic test_timeout();
        logic [5:0]  t;
        logic [27:0] d;
        int w, lat, rl, other;
        int snap [6];
        bit to;
        do_reset();
        res_ready = 1'b1;
        for (int b = 0; b < 6; b++) snap[b] = trig_hi[b];
        send_cfg(6'b000101);
        wait_trig(100, t, w, lat, to);
        n_checks++; if (to || t !== 6'h01) $display("FAIL tmo_trig0 got=%h exp=01", t); else n_pass++;
        wait_res(12000, d, rl, to);
        n_checks++; if (to || d !== 28'h001_0000) $display("FAIL tmo_res0 got=%h exp=0010000", d); else n_pass++;
        n_checks++;
        if (rl < 9998 || rl > 10002) $display("FAIL tmo_time got=%0d exp=10000", rl); else n_pass++;
        wait_trig(5000, t, w, lat, to);
        n_checks++; if (to || t !== 6'h04) $display("FAIL tmo_trig2 got=%h exp=04", t); else n_pass++;
        wait_res(12000, d, rl, to);
        n_checks++; if (to || d !== 28'h201_0000) $display("FAIL tmo_res2 got=%h exp=2010000", d); else n_pass++;
        wait_trig(5000, t, w, lat, to);
        n_checks++; if (to || t !== 6'h01) $display("FAIL tmo_wrap got=%h exp=01", t); else n_pass++;
        send_cfg(6'h00);
        other = (trig_hi[1] - snap[1]) + (trig_hi[3] - snap[3]) +
                (trig_hi[4] - snap[4]) + (trig_hi[5] - snap[5]);
        n_checks++; if (other !== 0) $display("FAIL tmo_disabled_trig got=%0d exp=0", other); else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [5:0]  t;
        logic [27:0] d;
        int w, lat, rl, bad_v, bad_d, bad_t;
        bit to;
        do_reset();
        res_ready = 1'b0;
        send_cfg(6'b000010);
        wait_trig(100, t, w, lat, to);
        n_checks++; if (to || t !== 6'h02) $display("FAIL bp_trig got=%h exp=02", t); else n_pass++;
        repeat (250) @(negedge clk);
        echo[1] = 1'b1;
        repeat (475) @(negedge clk);
        echo[1] = 1'b0;
        wait_res(2000, d, rl, to);
        n_checks++; if (to || d !== 28'h100_0009) $display("FAIL bp_res got=%h exp=1000009", d); else n_pass++;
        bad_v = 0; bad_d = 0; bad_t = 0;
        repeat (2000) begin
            @(negedge clk);
            if (res_valid !== 1'b1) bad_v++;
            if (res_data !== 28'h100_0009) bad_d++;
            if (trig !== 6'h00) bad_t++;
        end
        n_checks++; if (bad_v !== 0) $display("FAIL bp_valid_drop got=%0d exp=0", bad_v); else n_pass++;
        n_checks++; if (bad_d !== 0) $display("FAIL bp_data_change got=%0d exp=0", bad_d); else n_pass++;
        n_checks++; if (bad_t !== 0) $display("FAIL bp_trig_fired got=%0d exp=0", bad_t); else n_pass++;
        res_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (res_valid !== 1'b0) $display("FAIL bp_accept got=%b exp=0", res_valid); else n_pass++;
        n_checks++; if (busy !== 1'b1) $display("FAIL bp_gap_busy got=%b exp=1", busy); else n_pass++;
        send_cfg(6'h00);
    endtask

    task automatic test_abort();
        logic [5:0] t;
        int w, lat, seen;
        bit to;
        do_reset();
        res_ready = 1'b1;
        send_cfg(6'b001000);
        wait_trig(100, t, w, lat, to);
        n_checks++; if (to || t !== 6'h08) $display("FAIL abort_trig got=%h exp=08", t); else n_pass++;
        repeat (10) @(negedge clk);
        echo[3] = 1'b1;
        repeat (100) @(negedge clk);
        cfg_mask = 6'h00; cfg_valid = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
        n_checks++; if (trig !== 6'h00) $display("FAIL abort_trig_low got=%h exp=00", trig); else n_pass++;
        n_checks++; if (res_valid !== 1'b0) $display("FAIL abort_valid got=%b exp=0", res_valid); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL abort_busy got=%b exp=0", busy); else n_pass++;
        echo[3] = 1'b0;
        seen = 0;
        repeat (2000) begin
            @(negedge clk);
            if (res_valid !== 1'b0 || trig !== 6'h00) seen++;
        end
        n_checks++; if (seen !== 0) $display("FAIL abort_no_result got=%0d exp=0", seen); else n_pass++;
    endtask

    task automatic test_stuck_echo();
        logic [5:0]  t;
        logic [27:0] d;
        int w, lat, rl;
        bit to;
        do_reset();
        res_ready = 1'b1;
        echo[0] = 1'b1;
        repeat (5) @(negedge clk);
        send_cfg(6'b000001);
        wait_trig(100, t, w, lat, to);
        n_checks++; if (to || t !== 6'h01) $display("FAIL stuck_trig got=%h exp=01", t); else n_pass++;
        wait_res(12000, d, rl, to);
        n_checks++; if (to || d !== 28'h001_0000) $display("FAIL stuck_res got=%h exp=0010000", d); else n_pass++;
        echo = '0;
        send_cfg(6'h00);
    endtask

    task automatic test_reset_in_trig();
        bit found;
        int seen;
        send_cfg(6'b010000);
        found = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (trig === 6'h10) begin found = 1'b1; break; end
        end
        n_checks++; if (!found) $display("FAIL rst_trig_start got=%h exp=10", trig); else n_pass++;
        repeat (100) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (trig !== 6'h00) $display("FAIL rst_trig_low got=%h exp=00", trig); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy got=%b exp=0", busy); else n_pass++;
        n_checks++; if (res_data !== 28'h0) $display("FAIL rst_data got=%h exp=0", res_data); else n_pass++;
        rst = 1'b0;
        seen = 0;
        repeat (2000) begin
            @(negedge clk);
            if (res_valid !== 1'b0 || trig !== 6'h00) seen++;
        end
        n_checks++; if (seen !== 0) $display("FAIL rst_no_result got=%0d exp=0", seen); else n_pass++;
    endtask

    initial begin
        rst = 1'b1; cfg_valid = 1'b0; cfg_mask = '0; echo = '0; res_ready = 1'b0;
        test_reset();
        test_full_scan();
        test_timeout();
        test_backpressure();
        test_abort();
        test_stuck_echo();
        test_reset_in_trig();
        n_checks++;
        if (onehot_bad !== 0) $display("FAIL trig_onehot got=%0d exp=0", onehot_bad); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
